// File: rtl/seq_timing_controller_pkg.sv
// Shared constants for the sequence timing controller.
//   - phase encoding (IDLE/FETCH/DECODE/EXECUTE/INTR)
//   - sequence counter and timing bus widths
//   - last sequence count of the interrupt cycle
package seq_timing_controller_pkg;

    localparam int SC_WIDTH = 4;
    localparam int T_WIDTH  = 16;

    localparam logic [2:0] PH_IDLE    = 3'd0;
    localparam logic [2:0] PH_FETCH   = 3'd1;
    localparam logic [2:0] PH_DECODE  = 3'd2;
    localparam logic [2:0] PH_EXECUTE = 3'd3;
    localparam logic [2:0] PH_INTR    = 3'd4;

    localparam logic [SC_WIDTH-1:0] SC_MAX    = '1;
    localparam logic [SC_WIDTH-1:0] INTR_LAST = SC_WIDTH'(2);

endpackage

// File: rtl/seq_timing_controller_sc_decoder.sv
// sc_decoder: one-hot decode of the sequence count into timing signals.
//   en  - when low every timing line is held at zero
//   sc  - sequence count
//   t   - one-hot timing bus, t[sc] high when enabled
module sc_decoder
    import seq_timing_controller_pkg::*;
#(
    parameter int SC_W = SC_WIDTH,
    parameter int T_W  = T_WIDTH
) (
    input  logic            en,
    input  logic [SC_W-1:0] sc,
    output logic [T_W-1:0]  t
);

    for (genvar i = 0; i < T_W; i++) begin : g_line
        assign t[i] = en && (sc == SC_W'(i));
    end

endmodule

// File: rtl/seq_timing_controller.sv
// seq_timing_controller: instruction timing sequencer.
// Steps a sequence counter through FETCH (FETCH_LEN cycles), one DECODE
// cycle and EXECUTE until the execute logic signals end of instruction.
// Interrupts and halt requests are taken only at instruction boundaries.
//   clk, rst   - clock, synchronous active-high reset
//   start      - leave IDLE and begin fetching
//   halt_req   - stop at the next instruction boundary
//   sc_clr     - end of instruction from execute logic
//   ien        - interrupt enable
//   irq_pend   - device interrupt pending
//   sc, t      - sequence count and its one-hot decode
//   phase      - current phase code
//   r_flag     - interrupt cycle in progress
//   running    - not IDLE
//   irq_ack    - pulse on the last interrupt-cycle count
//   overrun    - pulse after EXECUTE wrapped past the top count
module seq_timing_controller
    import seq_timing_controller_pkg::*;
#(
    parameter int FETCH_LEN = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                halt_req,
    input  logic                sc_clr,
    input  logic                ien,
    input  logic                irq_pend,
    output logic [SC_WIDTH-1:0] sc,
    output logic [T_WIDTH-1:0]  t,
    output logic [2:0]          phase,
    output logic                r_flag,
    output logic                running,
    output logic                irq_ack,
    output logic                overrun
);

    localparam logic [SC_WIDTH-1:0] FETCH_LAST = SC_WIDTH'(FETCH_LEN - 1);

    logic [2:0]          phase_q;
    logic [SC_WIDTH-1:0] sc_q;
    logic                r_flag_q;
    logic                halt_pend;
    logic                overrun_q;
    logic                boundary;
    logic                halt_eff;

    // A halt request arriving in the boundary cycle itself is honoured there.
    assign halt_eff = halt_pend || halt_req;
    // The wrap past the top count is an instruction boundary too.
    assign boundary = (phase_q == PH_EXECUTE) && (sc_clr || (sc_q == SC_MAX));

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q   <= PH_IDLE;
            sc_q      <= '0;
            r_flag_q  <= 1'b0;
            halt_pend <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= 1'b0;
            if (phase_q != PH_IDLE && halt_req)
                halt_pend <= 1'b1;
            case (phase_q)
                PH_IDLE: begin
                    if (start) begin
                        phase_q <= PH_FETCH;
                        sc_q    <= '0;
                    end
                end
                PH_FETCH: begin
                    sc_q <= sc_q + 1'b1;
                    if (sc_q == FETCH_LAST)
                        phase_q <= PH_DECODE;
                end
                PH_DECODE: begin
                    sc_q    <= sc_q + 1'b1;
                    phase_q <= PH_EXECUTE;
                end
                PH_EXECUTE: begin
                    if (boundary) begin
                        sc_q      <= '0;
                        overrun_q <= !sc_clr;
                        // Interrupt wins; a pending halt survives until INTR ends.
                        if (ien && irq_pend) begin
                            phase_q  <= PH_INTR;
                            r_flag_q <= 1'b1;
                        end else if (halt_eff) begin
                            phase_q   <= PH_IDLE;
                            halt_pend <= 1'b0;
                        end else begin
                            phase_q <= PH_FETCH;
                        end
                    end else begin
                        sc_q <= sc_q + 1'b1;
                    end
                end
                PH_INTR: begin
                    if (sc_q == INTR_LAST) begin
                        sc_q     <= '0;
                        r_flag_q <= 1'b0;
                        if (halt_eff) begin
                            phase_q   <= PH_IDLE;
                            halt_pend <= 1'b0;
                        end else begin
                            phase_q <= PH_FETCH;
                        end
                    end else begin
                        sc_q <= sc_q + 1'b1;
                    end
                end
                default: begin
                    phase_q <= PH_IDLE;
                    sc_q    <= '0;
                end
            endcase
        end
    end

    assign sc      = sc_q;
    assign phase   = phase_q;
    assign r_flag  = r_flag_q;
    assign running = (phase_q != PH_IDLE);
    assign irq_ack = (phase_q == PH_INTR) && (sc_q == INTR_LAST);
    assign overrun = overrun_q;

    sc_decoder #(
        .SC_W (SC_WIDTH),
        .T_W  (T_WIDTH)
    ) u_dec (
        .en (running),
        .sc (sc_q),
        .t  (t)
    );

endmodule
